dmem_req_queue: RTL and testbench
=================================

DMEM_REQ_QUEUE -- requirements
Module: dmem_req_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the number of request FIFO entries; it SHALL be a power of two, 2..16.
REQ-002 Parameter MAX_OUT, default 8, is the maximum number of in-flight requests awaiting response; it SHALL be 1..15.
REQ-003 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 enq_addr/enq_op/enq_data/enq_wmask/enq_tag  in  32/4/64/8/12  request fields from the CP.
REQ-006 enq_val  in  1 / enq_rdy  out  1  enqueue handshake.
REQ-007 dmem_req4_addr/op/data/wmask/tag  out  32/4/64/8/12  head-entry fields toward the crossbar CP port.
REQ-008 dmem_req4_val  out  1 / dmem_req4_rdy  in  1  dequeue handshake.
REQ-009 dmem_resp4_val  in  1  one response returned for a previously issued request.
REQ-010 count  out  clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 outstanding  out  4  current in-flight request count.
REQ-012 resp_err  out  1  sticky flag: a response arrived with nothing outstanding.

Function
REQ-013 An enqueue fire SHALL occur when enq_val & enq_rdy are both 1; a dequeue fire SHALL occur when dmem_req4_val & dmem_req4_rdy are both 1.
REQ-014 enq_rdy SHALL equal (count != DEPTH), registered-state only, with no combinational dependence on dmem_req4_rdy.
REQ-015 dmem_req4_val SHALL equal (count != 0) & (outstanding < MAX_OUT).
REQ-016 dmem_req4_* fields SHALL be driven directly from the head entry; they SHALL hold stable while dmem_req4_val=1 and no dequeue fires.
REQ-017 The FIFO SHALL have no bypass: an entry enqueued in cycle N SHALL be presentable no earlier than cycle N+1.
REQ-018 Read and write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL distinguish full from empty.
REQ-019 A simultaneous enqueue and dequeue fire SHALL leave count unchanged and advance both pointers.
REQ-020 When full, enq_rdy=0 even if a dequeue fires in the same cycle; the freed slot SHALL be usable the next cycle.
REQ-021 Entries SHALL be dequeued in strict enqueue order; no fields SHALL be modified in the queue.
REQ-022 outstanding SHALL increment on a dequeue fire and decrement on dmem_resp4_val; when both occur in one cycle it SHALL be unchanged.
REQ-023 dmem_resp4_val with outstanding=0 and no dequeue fire in the same cycle SHALL leave outstanding at 0 and set resp_err to 1 until reset.
REQ-024 While outstanding=MAX_OUT, dmem_req4_val SHALL be 0; a response in that cycle SHALL re-enable dmem_req4_val the next cycle.
REQ-025 The queue SHALL never change state on an enq_val or dmem_req4_rdy without its matching valid/ready partner.

Reset
REQ-026 While reset_n=0, pointers, count, outstanding and resp_err SHALL be 0; hence enq_rdy=1 and dmem_req4_val=0 immediately, without waiting for a clock edge.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries and all in-flight accounting; storage contents need not be cleared.
REQ-028 The first enqueue SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-029 Fill: dmem_req4_rdy=0, enqueue 4 requests with tags 1..4 -> count=4, enq_rdy=0 after the 4th, 5th enq_val is not accepted.
REQ-030 Order/wrap: enqueue tags 0..9 with dmem_req4_rdy toggling -> dequeued tags are exactly 0..9 in order, and all fields match.
REQ-031 Full + simultaneous: while full, pulse dmem_req4_rdy=1 with enq_val=1 -> count=3 next cycle, enq_rdy=1; the following cycle's enqueue is accepted.
REQ-032 Credit limit: MAX_OUT=8, 10 queued, dmem_req4_rdy=1, no responses -> exactly 8 dequeue, outstanding=8, dmem_req4_val=0; one dmem_resp4_val pulse -> the 9th dequeues the next cycle.
REQ-033 Spurious response: dmem_resp4_val=1 at outstanding=0 -> outstanding stays 0, resp_err=1 and stays 1.
REQ-034 Async reset: with count=3 and outstanding=5, drop reset_n between clock edges -> count=0, outstanding=0, dmem_req4_val=0, enq_rdy=1 immediately.

Source files
------------

// File: rtl/dmem_req_queue.sv
// dmem_req_queue: CP-side data-memory request FIFO with response credit
// accounting in front of the crossbar CP port.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   enq_*                 request fields + valid/ready from the CP
//   dmem_req4_*           head-entry fields + valid/ready toward the crossbar
//   dmem_resp4_val        one response returned for an issued request
//   count                 FIFO occupancy (0..DEPTH)
//   outstanding           issued requests still awaiting a response
//   resp_err              sticky: a response arrived with nothing outstanding
module dmem_req_queue #(
    parameter int DEPTH   = 4,  // power of two, 2..16
    parameter int MAX_OUT = 8   // 1..15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              enq_addr,
    input  logic [3:0]               enq_op,
    input  logic [63:0]              enq_data,
    input  logic [7:0]               enq_wmask,
    input  logic [11:0]              enq_tag,
    input  logic                     enq_val,
    output logic                     enq_rdy,
    output logic [31:0]              dmem_req4_addr,
    output logic [3:0]               dmem_req4_op,
    output logic [63:0]              dmem_req4_data,
    output logic [7:0]               dmem_req4_wmask,
    output logic [11:0]              dmem_req4_tag,
    output logic                     dmem_req4_val,
    input  logic                     dmem_req4_rdy,
    input  logic                     dmem_resp4_val,
    output logic [$clog2(DEPTH):0]   count,
    output logic [3:0]               outstanding,
    output logic                     resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  op;
        logic [63:0] data;
        logic [7:0]  wmask;
        logic [11:0] tag;
    } req_t;

    req_t          mem_q [DEPTH];
    req_t          enq_req;
    req_t          head;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    outstanding_q, outstanding_d;
    logic          resp_err_q, resp_err_d;
    logic          enq_fire, deq_fire;

    assign enq_req = '{addr: enq_addr, op: enq_op, data: enq_data,
                       wmask: enq_wmask, tag: enq_tag};
    assign head    = mem_q[rd_ptr_q];

    // Ready/valid come only from registered state, so there is no
    // combinational path from dmem_req4_rdy to enq_rdy and no bypass.
    assign enq_rdy       = (count_q != CW'(DEPTH));
    assign dmem_req4_val = (count_q != '0) && (outstanding_q < 4'(MAX_OUT));

    assign enq_fire = enq_val & enq_rdy;
    assign deq_fire = dmem_req4_val & dmem_req4_rdy;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        resp_err_d    = resp_err_q;

        if (enq_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (deq_fire) rd_ptr_d = rd_ptr_q + 1'b1;

        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Issue and response in the same cycle cancel out; a lone response
        // with nothing in flight is flagged instead of underflowing.
        case ({deq_fire, dmem_resp4_val})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01: begin
                if (outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
                else                     resp_err_d    = 1'b1;
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            resp_err_q    <= resp_err_d;
        end
    end

    // Storage is not reset; pointers/count alone define what is valid.
    always_ff @(posedge clk) begin
        if (enq_fire) mem_q[wr_ptr_q] <= enq_req;
    end

    assign dmem_req4_addr  = head.addr;
    assign dmem_req4_op    = head.op;
    assign dmem_req4_data  = head.data;
    assign dmem_req4_wmask = head.wmask;
    assign dmem_req4_tag   = head.tag;

    assign count       = count_q;
    assign outstanding = outstanding_q;
    assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_dmem_req_queue.sv
// tb_dmem_req_queue: directed self-checking bench for dmem_req_queue
// (DEPTH=4, MAX_OUT=8). Inputs change and outputs are sampled 1-2 time
// units after each rising edge.
module tb_dmem_req_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] enq_addr;
    logic [3:0]  enq_op;
    logic [63:0] enq_data;
    logic [7:0]  enq_wmask;
    logic [11:0] enq_tag;
    logic        enq_val;
    logic        enq_rdy;
    logic [31:0] dmem_req4_addr;
    logic [3:0]  dmem_req4_op;
    logic [63:0] dmem_req4_data;
    logic [7:0]  dmem_req4_wmask;
    logic [11:0] dmem_req4_tag;
    logic        dmem_req4_val;
    logic        dmem_req4_rdy;
    logic        dmem_resp4_val;
    logic [2:0]  count;
    logic [3:0]  outstanding;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_req_queue #(.DEPTH(4), .MAX_OUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .enq_addr(enq_addr), .enq_op(enq_op), .enq_data(enq_data),
        .enq_wmask(enq_wmask), .enq_tag(enq_tag),
        .enq_val(enq_val), .enq_rdy(enq_rdy),
        .dmem_req4_addr(dmem_req4_addr), .dmem_req4_op(dmem_req4_op),
        .dmem_req4_data(dmem_req4_data), .dmem_req4_wmask(dmem_req4_wmask),
        .dmem_req4_tag(dmem_req4_tag), .dmem_req4_val(dmem_req4_val),
        .dmem_req4_rdy(dmem_req4_rdy), .dmem_resp4_val(dmem_resp4_val),
        .count(count), .outstanding(outstanding), .resp_err(resp_err)
    );

    // Request fields are a fixed function of the tag so the bench can
    // recompute what every dequeued entry must carry.
    function automatic logic [31:0] f_addr(int t);  return 32'h1000_0000 + 32'(t * 4); endfunction
    function automatic logic [3:0]  f_op(int t);    return 4'(t + 3); endfunction
    function automatic logic [63:0] f_data(int t);  return {32'hDEAD_0000 | 32'(t), ~32'(t)}; endfunction
    function automatic logic [7:0]  f_wmask(int t); return 8'(t * 3 + 1); endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enq(input logic v, input int t);
        enq_val   = v;
        enq_tag   = 12'(t);
        enq_addr  = f_addr(t);
        enq_op    = f_op(t);
        enq_data  = f_data(t);
        enq_wmask = f_wmask(t);
    endtask

    task automatic apply_reset();
        reset_n        = 1'b0;
        dmem_req4_rdy  = 1'b0;
        dmem_resp4_val = 1'b0;
        set_enq(1'b0, 0);
        step();
        step();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        dmem_req4_rdy  = 1'b0;
        dmem_resp4_val = 1'b0;
        set_enq(1'b0, 0);
        #2;
        n_checks++; if (count !== 3'd0)       begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
        n_checks++; if (enq_rdy !== 1'b1)     begin n_fail++; $display("FAIL rst_enq_rdy: got %b expected 1", enq_rdy); end
        n_checks++; if (dmem_req4_val !== 1'b0) begin n_fail++; $display("FAIL rst_req_val: got %b expected 0", dmem_req4_val); end
        n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
        n_checks++; if (resp_err !== 1'b0)    begin n_fail++; $display("FAIL rst_resp_err: got %b expected 0", resp_err); end
        step();
        @(negedge clk);
        reset_n = 1'b1;
        set_enq(1'b1, 7);
        #1;
        // No bypass: the entry being offered is not yet presentable.
        n_checks++; if (dmem_req4_val !== 1'b0) begin n_fail++; $display("FAIL no_bypass: got %b expected 0", dmem_req4_val); end
        step();
        set_enq(1'b0, 0);
        n_checks++; if (count !== 3'd1)         begin n_fail++; $display("FAIL first_enq_count: got %0d expected 1", count); end
        n_checks++; if (dmem_req4_val !== 1'b1) begin n_fail++; $display("FAIL first_enq_val: got %b expected 1", dmem_req4_val); end
        n_checks++; if (dmem_req4_tag !== 12'd7) begin n_fail++; $display("FAIL first_enq_tag: got %0d expected 7", dmem_req4_tag); end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            set_enq(1'b1, i);
            #1;
            n_checks++; if (enq_rdy !== 1'b1) begin n_fail++; $display("FAIL fill_rdy_%0d: got %b expected 1", i, enq_rdy); end
            step();
        end
        n_checks++; if (count !== 3'd4)   begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end
        n_checks++; if (enq_rdy !== 1'b0) begin n_fail++; $display("FAIL fill_full_rdy: got %b expected 0", enq_rdy); end
        set_enq(1'b1, 5);
        step();
        step();
        n_checks++; if (count !== 3'd4)          begin n_fail++; $display("FAIL fill_5th_rejected: got %0d expected 4", count); end
        n_checks++; if (dmem_req4_tag !== 12'd1) begin n_fail++; $display("FAIL fill_head_stable: got %0d expected 1", dmem_req4_tag); end
        n_checks++; if (outstanding !== 4'd0)    begin n_fail++; $display("FAIL fill_no_issue: got %0d expected 0", outstanding); end
    endtask

    // Continues from the full queue left by test_fill.
    task automatic test_full_simultaneous();
        set_enq(1'b1, 5);
        dmem_req4_rdy = 1'b1;
        #1;
        n_checks++; if (enq_rdy !== 1'b0) begin n_fail++; $display("FAIL full_simul_rdy: got %b expected 0", enq_rdy); end
        step();
        dmem_req4_rdy = 1'b0;
        n_checks++; if (count !== 3'd3)          begin n_fail++; $display("FAIL full_simul_count: got %0d expected 3", count); end
        n_checks++; if (enq_rdy !== 1'b1)        begin n_fail++; $display("FAIL full_simul_rdy_next: got %b expected 1", enq_rdy); end
        n_checks++; if (outstanding !== 4'd1)    begin n_fail++; $display("FAIL full_simul_out: got %0d expected 1", outstanding); end
        n_checks++; if (dmem_req4_tag !== 12'd2) begin n_fail++; $display("FAIL full_simul_head: got %0d expected 2", dmem_req4_tag); end
        step();
        set_enq(1'b0, 0);
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_simul_reuse: got %0d expected 4", count); end
    endtask

    task automatic test_order_wrap();
        int n_enq = 0;
        int exp_idx = 0;
        apply_reset();
        for (int cyc = 0; cyc < 80 && exp_idx < 10; cyc++) begin
            set_enq(n_enq < 10, n_enq);
            dmem_req4_rdy  = cyc[0];
            dmem_resp4_val = (outstanding != 4'd0) && (cyc % 3 == 0);
            #1;
            if (dmem_req4_val && dmem_req4_rdy) begin
                n_checks++;
                if (dmem_req4_tag !== 12'(exp_idx)) begin
                    n_fail++; $display("FAIL order_tag: got %0d expected %0d", dmem_req4_tag, exp_idx);
                end
                n_checks++;
                if ({dmem_req4_addr, dmem_req4_op, dmem_req4_data, dmem_req4_wmask} !==
                    {f_addr(exp_idx), f_op(exp_idx), f_data(exp_idx), f_wmask(exp_idx)}) begin
                    n_fail++; $display("FAIL order_fields_%0d: got %h/%h/%h/%h expected %h/%h/%h/%h", exp_idx,
                        dmem_req4_addr, dmem_req4_op, dmem_req4_data, dmem_req4_wmask,
                        f_addr(exp_idx), f_op(exp_idx), f_data(exp_idx), f_wmask(exp_idx));
                end
                exp_idx++;
            end
            if (enq_val && enq_rdy) n_enq++;
            step();
        end
        set_enq(1'b0, 0);
        dmem_req4_rdy  = 1'b0;
        dmem_resp4_val = 1'b0;
        n_checks++; if (exp_idx !== 10) begin n_fail++; $display("FAIL order_all_dequeued: got %0d expected 10", exp_idx); end
    endtask

    task automatic test_credit_limit();
        int n_enq = 0;
        int n_deq = 0;
        apply_reset();
        dmem_req4_rdy = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            set_enq(n_enq < 10, n_enq);
            #1;
            if (dmem_req4_val) n_deq++;
            if (enq_val && enq_rdy) n_enq++;
            step();
        end
        set_enq(1'b0, 0);
        n_checks++; if (n_deq !== 8)             begin n_fail++; $display("FAIL credit_deq_count: got %0d expected 8", n_deq); end
        n_checks++; if (outstanding !== 4'd8)    begin n_fail++; $display("FAIL credit_outstanding: got %0d expected 8", outstanding); end
        n_checks++; if (count !== 3'd2)          begin n_fail++; $display("FAIL credit_count: got %0d expected 2", count); end
        dmem_resp4_val = 1'b1;
        #1;
        n_checks++; if (dmem_req4_val !== 1'b0)  begin n_fail++; $display("FAIL credit_val_blocked: got %b expected 0", dmem_req4_val); end
        step();
        dmem_resp4_val = 1'b0;
        n_checks++; if (outstanding !== 4'd7)    begin n_fail++; $display("FAIL credit_resp_dec: got %0d expected 7", outstanding); end
        n_checks++; if (dmem_req4_val !== 1'b1)  begin n_fail++; $display("FAIL credit_val_reenabled: got %b expected 1", dmem_req4_val); end
        n_checks++; if (dmem_req4_tag !== 12'd8) begin n_fail++; $display("FAIL credit_9th_tag: got %0d expected 8", dmem_req4_tag); end
        step();
        n_checks++; if (outstanding !== 4'd8)    begin n_fail++; $display("FAIL credit_9th_issued: got %0d expected 8", outstanding); end
        n_checks++; if (count !== 3'd1)          begin n_fail++; $display("FAIL credit_9th_count: got %0d expected 1", count); end
        dmem_req4_rdy = 1'b0;
    endtask

    task automatic test_spurious_resp();
        apply_reset();
        set_enq(1'b1, 3);
        step();
        set_enq(1'b0, 0);
        // Issue and response together at outstanding=0: net zero, no error.
        dmem_req4_rdy  = 1'b1;
        dmem_resp4_val = 1'b1;
        step();
        dmem_req4_rdy  = 1'b0;
        dmem_resp4_val = 1'b0;
        n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL simul_issue_resp_out: got %0d expected 0", outstanding); end
        n_checks++; if (resp_err !== 1'b0)    begin n_fail++; $display("FAIL simul_issue_resp_err: got %b expected 0", resp_err); end
        dmem_resp4_val = 1'b1;
        step();
        dmem_resp4_val = 1'b0;
        n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL spurious_out: got %0d expected 0", outstanding); end
        n_checks++; if (resp_err !== 1'b1)    begin n_fail++; $display("FAIL spurious_err: got %b expected 1", resp_err); end
        step();
        step();
        step();
        n_checks++; if (resp_err !== 1'b1)    begin n_fail++; $display("FAIL spurious_sticky: got %b expected 1", resp_err); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        dmem_req4_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_enq(1'b1, 20 + i);
            step();
        end
        dmem_req4_rdy = 1'b0;
        for (int i = 6; i < 8; i++) begin
            set_enq(1'b1, 20 + i);
            step();
        end
        set_enq(1'b0, 0);
        n_checks++; if (count !== 3'd3)       begin n_fail++; $display("FAIL areset_pre_count: got %0d expected 3", count); end
        n_checks++; if (outstanding !== 4'd5) begin n_fail++; $display("FAIL areset_pre_out: got %0d expected 5", outstanding); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0)         begin n_fail++; $display("FAIL areset_count: got %0d expected 0", count); end
        n_checks++; if (outstanding !== 4'd0)   begin n_fail++; $display("FAIL areset_out: got %0d expected 0", outstanding); end
        n_checks++; if (dmem_req4_val !== 1'b0) begin n_fail++; $display("FAIL areset_val: got %b expected 0", dmem_req4_val); end
        n_checks++; if (enq_rdy !== 1'b1)       begin n_fail++; $display("FAIL areset_rdy: got %b expected 1", enq_rdy); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_simultaneous();
        test_order_wrap();
        test_credit_limit();
        test_spurious_resp();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
